cpu_ctrl_fsm: RTL and testbench
===============================

// Module: cpu_ctrl_fsm
// PURPOSE
//  Multi-cycle control sequencer for the 16-bit CPU datapath.
//  Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives all datapath enables and selects.
//  Owns the shared memory port for both instruction and data accesses, using a req/ack handshake.
//  Sits beside the datapath inside CPU; the datapath supplies the instruction register and the ALU zero flag.
// PARAMETERS
//  CNT_W   16   width of retired-instruction counter
// PORTS
//  clk          in   1   system clock, rising edge
//  reset_n      in   1   asynchronous active-low reset
//  start        in   1   leave IDLE and begin fetching
//  instr        in   16  current IR contents; opcode=[15:12], funct=[2:0]
//  zero         in   1   ALU zero flag, valid in EXEC
//  mem_ack      in   1   memory completes the current request this cycle
//  mem_req      out  1   memory request, held until mem_ack
//  mem_we       out  1   1=write (SW only)
//  mem_sel      out  1   address select: 0=PC (fetch), 1=ALU result (data)
//  ir_we        out  1   load IR from memory read data
//  pc_we        out  1   PC write enable
//  pc_src       out  2   00=PC+2, 01=branch target, 10=jump target
//  reg_we       out  1   register-file write enable
//  wb_sel       out  1   writeback source: 0=ALU, 1=memory
//  alu_src      out  1   ALU B operand: 0=register, 1=sign-extended immediate
//  alu_op       out  3   ALU operation code
//  busy         out  1   state is neither IDLE nor HALT
//  halted       out  1   state is HALT
//  illegal      out  1   one-cycle pulse on an undefined opcode
//  instr_count  out  CNT_W  retired instructions
// BEHAVIOUR
//  Opcodes: 0000 R, 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 0101 J, 1111 HALT; all others illegal.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
//  State register only; all control outputs decode combinationally from state, instr and mem_ack.
//  Outputs not listed for a state are 0. Default alu_op is 000.
//  Reset (async): state=IDLE, instr_count=0, every output 0. mem_req drops immediately, even mid-access.
//  IDLE: start=1 -> FETCH on the next edge.
//  FETCH: mem_req=1, mem_sel=0.
//   - While mem_ack=0, stay in FETCH (wait states allowed).
//   - With mem_ack=1: ir_we=1, pc_we=1, pc_src=00 -> DECODE.
//  DECODE: one cycle, no enables -> EXEC.
//  EXEC, by opcode:
//   - R: alu_op=funct -> WB.
//   - ADDI: alu_src=1, alu_op=000 -> WB.
//   - LW/SW: alu_src=1, alu_op=000 -> MEM.
//   - BEQ: alu_op=001 (sub), pc_we=zero, pc_src=01 -> FETCH; retires.
//   - J: pc_we=1, pc_src=10 -> FETCH; retires.
//   - HALT: -> HALT; retires.
//   - Illegal: illegal=1 -> FETCH; retires as NOP. PC already advanced in FETCH.
//  MEM: mem_req=1, mem_sel=1, mem_we=(SW), alu_src=1.
//   - Stay in MEM until mem_ack.
//   - On ack: SW -> FETCH (retires); LW -> WB.
//  WB: reg_we=1, wb_sel=(LW), alu_src=(ADDI|LW), alu_op as in EXEC -> FETCH; retires.
//  HALT: absorbing. start is ignored; only reset_n exits.
//  IDLE, DECODE, EXEC, WB, HALT: mem_ack is ignored.
//  instr_count: +1 on each retire edge; wraps modulo 2^CNT_W (0xFFFF -> 0x0000).
//  Zero-wait latency, fetch start to retire:
//   - R/ADDI/SW: 4 cycles
//   - LW: 5 cycles
//   - BEQ/J/HALT/illegal: 3 cycles
//  Each wait cycle adds 1.
//  instr is sampled only in EXEC/MEM/WB. The IR is stable because ir_we asserts only in FETCH.
// TESTING
//  1. Reset then start, mem_ack tied 1, instr=0x0001 (R, funct 001):
//     states FETCH,DECODE,EXEC,WB; reg_we=1 only in WB with alu_op=001; instr_count=1 after 4 cycles.
//  2. LW (0x2xxx), fetch ack after 2 wait cycles, data ack after 1 wait cycle:
//     mem_sel 0 then 1, mem_we=0, wb_sel=1 in WB; retire 8 cycles after FETCH entry.
//  3. BEQ (0x4xxx): with zero=1, pc_we=1 and pc_src=01 in EXEC; with zero=0, pc_we=0; both -> FETCH.
//  4. SW (0x3xxx): mem_we=1 only while in MEM; reg_we never asserts; next state FETCH.
//  5. Opcode 0x7 -> illegal pulses 1 cycle and execution continues.
//     HALT (0xF000) -> halted=1, busy=0; start=1 has no effect.
//  6. Assert reset_n=0 mid-MEM with mem_req=1: mem_req, busy and instr_count go 0 immediately.
//     Preload instr_count=0xFFFF, retire one instruction -> 0x0000.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 16-bit CPU: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, owns the shared memory port and counts retired instructions.
module cpu_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      instr,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_retire;
  logic [CNT_W-1:0] r_instr_count;
  logic [3:0]       w_opcode;
  logic [2:0]       w_funct;
  logic             w_unused;

  assign w_opcode    = instr[15:12];
  assign w_funct     = instr[2:0];
  assign w_unused    = ^instr[11:3];
  assign instr_count = r_instr_count;

  // State and retired-instruction counter; the counter wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_instr_count <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      if (w_retire) begin
        r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_instr_count <= r_instr_count;
      end
    end
  end

  // Next-state and control decode; every output defaults to 0 and is raised per state.
  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel      = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    reg_we       = 1'b0;
    wb_sel       = 1'b0;
    alu_src      = 1'b0;
    alu_op       = 3'b000;
    illegal      = 1'b0;
    busy         = (r_state != S_IDLE) && (r_state != S_HALT);
    halted       = (r_state == S_HALT);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_FETCH: begin
        mem_req = 1'b1;
        mem_sel = 1'b0;
        if (mem_ack) begin
          ir_we        = 1'b1;
          pc_we        = 1'b1;
          pc_src       = 2'b00;
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        w_next_state = S_EXEC;
      end
      S_EXEC: begin
        case (w_opcode)
          OP_R: begin
            alu_op       = w_funct;
            w_next_state = S_WB;
          end
          OP_ADDI: begin
            alu_src      = 1'b1;
            w_next_state = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src      = 1'b1;
            w_next_state = S_MEM;
          end
          OP_BEQ: begin
            alu_op       = 3'b001;
            pc_we        = zero;
            pc_src       = 2'b01;
            w_next_state = S_FETCH;
            w_retire     = 1'b1;
          end
          OP_J: begin
            pc_we        = 1'b1;
            pc_src       = 2'b10;
            w_next_state = S_FETCH;
            w_retire     = 1'b1;
          end
          OP_HALT: begin
            w_next_state = S_HALT;
            w_retire     = 1'b1;
          end
          default: begin
            // Undefined opcode retires as a NOP; the PC was already advanced in FETCH.
            illegal      = 1'b1;
            w_next_state = S_FETCH;
            w_retire     = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (w_opcode == OP_SW);
        alu_src = 1'b1;
        if (!mem_ack) begin
          w_next_state = S_MEM;
        end else if (w_opcode == OP_LW) begin
          w_next_state = S_WB;
        end else begin
          w_next_state = S_FETCH;
          w_retire     = 1'b1;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = (w_opcode == OP_LW);
        alu_src = (w_opcode == OP_ADDI) || (w_opcode == OP_LW);
        if (w_opcode == OP_R) begin
          alu_op = w_funct;
        end else begin
          alu_op = 3'b000;
        end
        w_next_state = S_FETCH;
        w_retire     = 1'b1;
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Table-driven directed bench for cpu_ctrl_fsm; a second 4-bit-counter instance exercises wrap.
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        zero = 1'b0;
  logic        mem_ack = 1'b0;

  logic        mem_req, mem_we, mem_sel, ir_we, pc_we, reg_we, wb_sel, alu_src, busy, halted, illegal;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op;
  logic [15:0] instr_count;

  logic        s_mem_req, s_mem_we, s_mem_sel, s_ir_we, s_pc_we, s_reg_we, s_wb_sel, s_alu_src;
  logic        s_busy, s_halted, s_illegal;
  logic [1:0]  s_pc_src;
  logic [2:0]  s_alu_op;
  logic [3:0]  s_instr_count;

  logic [15:0] w_out, w_out_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .instr(instr), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op),
    .busy(busy), .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  cpu_ctrl_fsm #(.CNT_W(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .start(start), .instr(instr), .zero(zero), .mem_ack(mem_ack),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_sel(s_mem_sel), .ir_we(s_ir_we), .pc_we(s_pc_we),
    .pc_src(s_pc_src), .reg_we(s_reg_we), .wb_sel(s_wb_sel), .alu_src(s_alu_src), .alu_op(s_alu_op),
    .busy(s_busy), .halted(s_halted), .illegal(s_illegal), .instr_count(s_instr_count)
  );

  assign w_out   = {mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src, reg_we, wb_sel, alu_src,
                    alu_op, busy, halted, illegal};
  assign w_out_s = {s_mem_req, s_mem_we, s_mem_sel, s_ir_we, s_pc_we, s_pc_src, s_reg_we, s_wb_sel,
                    s_alu_src, s_alu_op, s_busy, s_halted, s_illegal};

  typedef struct {
    logic        start;
    logic [15:0] instr;
    logic        zero;
    logic        ack;
    logic [15:0] exp_out;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] mk(input logic req, input logic we, input logic sel,
                                     input logic irwe, input logic pcwe, input logic [1:0] pcsrc,
                                     input logic regwe, input logic wbsel, input logic alusrc,
                                     input logic [2:0] aluop, input logic bsy, input logic hlt,
                                     input logic ill);
    return {req, we, sel, irwe, pcwe, pcsrc, regwe, wbsel, alusrc, aluop, bsy, hlt, ill};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic [15:0] ins, input logic z, input logic ack,
                     input logic [15:0] eo, input logic [15:0] ec);
    vec_t v;
    v.start = st; v.instr = ins; v.zero = z; v.ack = ack; v.exp_out = eo; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  // Drive at the falling edge, compare 2 time units later, well before the next rising edge.
  task automatic step(input logic st, input logic [15:0] ins, input logic z, input logic ack,
                      input logic [15:0] eo, input logic [15:0] ec, input string name);
    logic [3:0] ec_s;
    @(negedge clk);
    start = st; instr = ins; zero = z; mem_ack = ack;
    #2;
    ec_s = ec[3:0];
    chk({name, ".out"}, {16'h0, w_out}, {16'h0, eo});
    chk({name, ".cnt"}, {16'h0, instr_count}, {16'h0, ec});
    chk({name, ".out4"}, {16'h0, w_out_s}, {16'h0, eo});
    chk({name, ".cnt4"}, {28'h0, s_instr_count}, {28'h0, ec_s});
  endtask

  initial begin
    logic [15:0] o_fa, o_fw, o_d, o_alu_i, o_halt;
    o_fa    = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    o_fw    = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    o_d     = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    o_alu_i = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0);
    o_halt  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);

    // R-type funct 001, zero-wait: retires after 4 cycles
    add(1'b1, 16'h0001, 1'b0, 1'b1, 16'h0000, 16'd0);
    add(1'b0, 16'h0001, 1'b0, 1'b1, o_fa, 16'd0);
    add(1'b0, 16'h0001, 1'b0, 1'b1, o_d, 16'd0);
    add(1'b0, 16'h0001, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0), 16'd0);
    add(1'b0, 16'h0001, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0), 16'd0);
    // LW: two fetch wait states, one data wait state
    add(1'b0, 16'h2000, 1'b0, 1'b0, o_fw, 16'd1);
    add(1'b0, 16'h2000, 1'b0, 1'b0, o_fw, 16'd1);
    add(1'b0, 16'h2000, 1'b0, 1'b1, o_fa, 16'd1);
    add(1'b0, 16'h2000, 1'b0, 1'b1, o_d, 16'd1);
    add(1'b0, 16'h2000, 1'b0, 1'b0, o_alu_i, 16'd1);
    add(1'b0, 16'h2000, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0), 16'd1);
    add(1'b0, 16'h2000, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0), 16'd1);
    add(1'b0, 16'h2000, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0), 16'd1);
    // BEQ taken, then not taken
    add(1'b0, 16'h4000, 1'b1, 1'b1, o_fa, 16'd2);
    add(1'b0, 16'h4000, 1'b1, 1'b1, o_d, 16'd2);
    add(1'b0, 16'h4000, 1'b1, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0), 16'd2);
    add(1'b0, 16'h4000, 1'b0, 1'b1, o_fa, 16'd3);
    add(1'b0, 16'h4000, 1'b0, 1'b1, o_d, 16'd3);
    add(1'b0, 16'h4000, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0), 16'd3);
    // SW
    add(1'b0, 16'h3000, 1'b0, 1'b1, o_fa, 16'd4);
    add(1'b0, 16'h3000, 1'b0, 1'b1, o_d, 16'd4);
    add(1'b0, 16'h3000, 1'b0, 1'b1, o_alu_i, 16'd4);
    add(1'b0, 16'h3000, 1'b0, 1'b1, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0), 16'd4);
    // ADDI
    add(1'b0, 16'h1005, 1'b0, 1'b1, o_fa, 16'd5);
    add(1'b0, 16'h1005, 1'b0, 1'b1, o_d, 16'd5);
    add(1'b0, 16'h1005, 1'b0, 1'b1, o_alu_i, 16'd5);
    add(1'b0, 16'h1005, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0), 16'd5);
    // R-type funct 110
    add(1'b0, 16'h0006, 1'b0, 1'b1, o_fa, 16'd6);
    add(1'b0, 16'h0006, 1'b0, 1'b1, o_d, 16'd6);
    add(1'b0, 16'h0006, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0), 16'd6);
    add(1'b0, 16'h0006, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0), 16'd6);
    // J
    add(1'b0, 16'h5000, 1'b0, 1'b1, o_fa, 16'd7);
    add(1'b0, 16'h5000, 1'b0, 1'b1, o_d, 16'd7);
    add(1'b0, 16'h5000, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0), 16'd7);
    // illegal opcode 0x7
    add(1'b0, 16'h7000, 1'b0, 1'b1, o_fa, 16'd8);
    add(1'b0, 16'h7000, 1'b0, 1'b1, o_d, 16'd8);
    add(1'b0, 16'h7000, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1), 16'd8);
    // HALT; start and mem_ack ignored afterwards
    add(1'b0, 16'hF000, 1'b0, 1'b1, o_fa, 16'd9);
    add(1'b0, 16'hF000, 1'b0, 1'b1, o_d, 16'd9);
    add(1'b0, 16'hF000, 1'b0, 1'b1, o_d, 16'd9);
    add(1'b1, 16'hF000, 1'b0, 1'b1, o_halt, 16'd10);
    add(1'b1, 16'h0001, 1'b0, 1'b1, o_halt, 16'd10);
    add(1'b0, 16'hF000, 1'b0, 1'b0, o_halt, 16'd10);

    // Reset state, with start and mem_ack asserted against it
    #3;
    start = 1'b1; mem_ack = 1'b1; instr = 16'h0001;
    #1;
    chk("reset.out", {16'h0, w_out}, 32'h0);
    chk("reset.cnt", {16'h0, instr_count}, 32'h0);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].start, vecs[i].instr, vecs[i].zero, vecs[i].ack, vecs[i].exp_out,
           vecs[i].exp_cnt, $sformatf("vec%0d", i));
    end

    // Reset asserted mid-MEM with a nonzero counter
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    chk("halt_reset.halted", {31'h0, halted}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 16'h5000, 1'b0, 1'b1, 16'h0000, 16'd0, "mr.idle");
    step(1'b0, 16'h5000, 1'b0, 1'b1, o_fa, 16'd0, "mr.fetch_j");
    step(1'b0, 16'h5000, 1'b0, 1'b1, o_d, 16'd0, "mr.dec_j");
    step(1'b0, 16'h5000, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0), 16'd0, "mr.exec_j");
    step(1'b0, 16'h3000, 1'b0, 1'b1, o_fa, 16'd1, "mr.fetch_sw");
    step(1'b0, 16'h3000, 1'b0, 1'b1, o_d, 16'd1, "mr.dec_sw");
    step(1'b0, 16'h3000, 1'b0, 1'b1, o_alu_i, 16'd1, "mr.exec_sw");
    step(1'b0, 16'h3000, 1'b0, 1'b0, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0), 16'd1, "mr.mem");
    #1;
    reset_n = 1'b0;
    #1;
    chk("mr.mem_req", {31'h0, mem_req}, 32'h0);
    chk("mr.busy", {31'h0, busy}, 32'h0);
    chk("mr.cnt", {16'h0, instr_count}, 32'h0);
    chk("mr.out", {16'h0, w_out}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b0;

    // Counter wrap: 16 illegal NOPs on the 4-bit instance roll 0xF over to 0x0
    step(1'b1, 16'h7000, 1'b0, 1'b1, 16'h0000, 16'd0, "wrap.idle");
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 16'h7000, 1'b0, 1'b1, o_fa, 16'(i), $sformatf("wrap%0d.fetch", i));
      step(1'b0, 16'h7000, 1'b0, 1'b1, o_d, 16'(i), $sformatf("wrap%0d.dec", i));
      step(1'b0, 16'h7000, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1), 16'(i), $sformatf("wrap%0d.exec", i));
    end
    step(1'b0, 16'h7000, 1'b0, 1'b1, o_fa, 16'd16, "wrap.final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
